keypad_scanner: RTL and testbench

- Input-side counterpart of the dual seven-segment display driver. Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row inputs, and reports each accepted key press as a single-cycle pulse with a hex code.
- Keeps the two most recent digits (newest and previous) in registers. These drive the display driver's two 4-bit digit inputs directly.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/keypad_sync.sv | 32 +++
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 matrix keypad scanner.
//   - state_e           : scanner FSM states
//   - idx_t             : decoded 2-bit index plus a valid flag
//   - KEY_MAP           : hex code for each key, indexed {row, col}
//   - onehot_low_to_idx : decodes an active-low one-hot nibble to an index;
//                         valid is false when no bit or several bits are low
package keypad_pkg;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } idx_t;

  // Element [15] is row 3 / col 3, element [0] is row 0 / col 0.
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: E 0 F D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic idx_t onehot_low_to_idx(input logic [3:0] bits_n);
    idx_t r;
    r.vld = 1'b0;
    r.idx = 2'd0;
    case (bits_n)
      4'b1110: begin r.vld = 1'b1; r.idx = 2'd0; end
      4'b1101: begin r.vld = 1'b1; r.idx = 2'd1; end
      4'b1011: begin r.vld = 1'b1; r.idx = 2'd2; end
      4'b0111: begin r.vld = 1'b1; r.idx = 2'd3; end
      default: begin r.vld = 1'b0; r.idx = 2'd0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
//   Two-flop synchronizer for the asynchronous, active-low keypad rows.
//   Both stages reset to 4'hF (no key pressed) so the scanner never sees a
//   phantom press coming out of reset.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   row_n   in   [3:0] raw keypad rows, asynchronous to clk
//   rows_s  out  [3:0] synchronized rows, two cycles behind row_n
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] rows_s
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= row_n;
      sync_q <= meta_q;
    end
  end

  assign rows_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   both press and release, and reports each accepted press as a one-cycle
//   key_valid pulse with its hex code. The two most recent codes are kept
//   for the dual seven-segment display driver.
// Parameters:
//   SCAN_DIV   clock cycles each column is driven before advancing
//   DB_CYCLES  clock cycles of stable input to accept a press or release
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   row_n      in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_n      out  [3:0] column drive, one-hot active-low
//   key_valid  out  one-cycle pulse on an accepted press
//   key_code   out  [3:0] code of the last accepted key
//   dig_new    out  [3:0] most recent accepted digit
//   dig_old    out  [3:0] digit accepted before dig_new
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 4800,
  parameter int DB_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] dig_new,
  output logic [3:0] dig_old
);

  // One counter serves both the column dwell and the debounce intervals,
  // so it is sized for the longer of the two.
  localparam int CNT_MAX = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       rows_s;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [1:0]       col_idx_q,   col_idx_d;
  logic [1:0]       row_idx_q,   row_idx_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic [3:0]       dig_new_q,   dig_new_d;
  logic [3:0]       dig_old_q,   dig_old_d;

  idx_t             row_dec;
  logic [3:0]       row_pat;
  logic             row_up;
  logic [3:0]       new_code;

  // ---- input synchronizer: every decision below uses rows_s only ----
  keypad_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .row_n  (row_n),
    .rows_s (rows_s)
  );

  assign row_dec  = onehot_low_to_idx(rows_s);
  // Pattern the debounce must keep seeing: only the latched row low.
  assign row_pat  = ~(4'b0001 << row_idx_q);
  // While held, only the latched row matters; other rows are ignored.
  assign row_up   = rows_s[row_idx_q];
  assign new_code = KEY_MAP[{row_idx_q, col_idx_q}];

  // ---- next-state logic ----
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    dig_new_d   = dig_new_q;
    dig_old_d   = dig_old_q;

    case (state_q)
      S_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_dec.vld) begin
            // Column stays driven; col_idx_q already names the column.
            row_idx_d = row_dec.idx;
            state_d   = S_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DEBOUNCE: begin
        if (rows_s == row_pat) begin
          if (cnt_q == DB_LAST) begin
            key_valid_d = 1'b1;
            key_code_d  = new_code;
            dig_old_d   = dig_new_q;
            dig_new_d   = new_code;
            cnt_d       = '0;
            state_d     = S_HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = S_SCAN;
        end
      end

      S_HELD: begin
        if (row_up) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (!row_up) begin
          // Release bounce: back to holding, never a second pulse.
          state_d = S_HELD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = S_SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_SCAN;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SCAN;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      dig_new_q   <= 4'h0;
      dig_old_q   <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      dig_new_q   <= dig_new_d;
      dig_old_q   <= dig_old_d;
    end
  end

  // Column drive decoded from the registered index; frozen whenever the
  // FSM is not scanning because col_idx_q only advances on scan moves.
  assign col_n     = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign dig_new   = dig_new_q;
  assign dig_old   = dig_old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DB_CYCLES=8.
//   A behavioural keypad drives row_n from col_n and the set of pressed
//   keys. Stimulus pushes expected pulses into a scoreboard queue; a
//   monitor pops and compares on every key_valid pulse.
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DB_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] dig_new;
  logic [3:0] dig_old;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .dig_new   (dig_new),
    .dig_old   (dig_old)
  );

  // Pressed keys, bit index = row*4 + col.
  logic [15:0] pressed;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  typedef struct {
    logic [3:0] code;
    logic [3:0] dnew;
    logic [3:0] dold;
  } exp_t;

  exp_t       sb[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         pulse_cnt = 0;
  logic [3:0] m_new, m_old;
  logic       prev_vld  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.dnew = code;
    e.dold = m_new;
    sb.push_back(e);
    m_old = m_new;
    m_new = code;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: pulse not seen within 200 cycles, %0d pending", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every pulse must be expected, isolated, and carry the right data.
  always @(negedge clk) begin
    if (key_valid) begin
      exp_t e;
      pulse_cnt++;
      chk("pulse_not_back_to_back", {31'd0, prev_vld}, 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: key_code=%0h, expected no pulse", key_code);
      end else begin
        e = sb.pop_front();
        chk("pulse_key_code", {28'd0, key_code}, {28'd0, e.code});
        chk("pulse_dig_new",  {28'd0, dig_new},  {28'd0, e.dnew});
        chk("pulse_dig_old",  {28'd0, dig_old},  {28'd0, e.dold});
      end
    end
    prev_vld = key_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pc;
    int         t;
    logic [3:0] c0;

    reset   = 1'b1;
    pressed = 16'h0;
    m_new   = 4'h0;
    m_old   = 4'h0;

    // Reset state
    cyc(3);
    chk("rst_col_n",     {28'd0, col_n},    32'hE);
    chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_key_code",  {28'd0, key_code}, 32'h0);
    chk("rst_dig_new",   {28'd0, dig_new},  32'h0);
    chk("rst_dig_old",   {28'd0, dig_old},  32'h0);

    // Column rotation, one step every SCAN_DIV cycles
    reset = 1'b0;
    cyc(3);
    chk("scan_col_hold", {28'd0, col_n}, 32'hE);
    cyc(1);
    chk("scan_col_1", {28'd0, col_n}, 32'hD);
    cyc(4);
    chk("scan_col_2", {28'd0, col_n}, 32'hB);
    cyc(4);
    chk("scan_col_3", {28'd0, col_n}, 32'h7);
    cyc(4);
    chk("scan_col_wrap", {28'd0, col_n}, 32'hE);

    // '5' held clean, column frozen through the release debounce
    pressed[5] = 1'b1;
    expect_key(4'h5);
    wait_sb("press_5");
    chk("held5_col", {28'd0, col_n}, 32'hD);
    cyc(5);
    pressed = 16'h0;
    cyc(10);
    chk("release5_col_frozen", {28'd0, col_n}, 32'hD);
    cyc(3);
    chk("release5_col_advanced", {28'd0, col_n}, 32'hB);

    // '7' then 'A'
    cyc(4);
    pressed[8] = 1'b1;
    expect_key(4'h7);
    wait_sb("press_7");
    cyc(3);
    pressed = 16'h0;
    cyc(20);
    pressed[3] = 1'b1;
    expect_key(4'hA);
    wait_sb("press_A");
    cyc(3);
    pressed = 16'h0;
    cyc(20);
    chk("seq_dig_new", {28'd0, dig_new}, 32'hA);
    chk("seq_dig_old", {28'd0, dig_old}, 32'h7);

    // '3' twice shifts normally
    pressed[2] = 1'b1;
    expect_key(4'h3);
    wait_sb("press_3a");
    cyc(3);
    pressed = 16'h0;
    cyc(20);
    pressed[2] = 1'b1;
    expect_key(4'h3);
    wait_sb("press_3b");
    cyc(3);
    pressed = 16'h0;
    cyc(20);
    chk("repeat_dig_new", {28'd0, dig_new}, 32'h3);
    chk("repeat_dig_old", {28'd0, dig_old}, 32'h3);

    // '9' with press bounce
    pressed[10] = 1'b1;
    cyc(3);
    pressed[10] = 1'b0;
    cyc(2);
    pressed[10] = 1'b1;
    expect_key(4'h9);
    wait_sb("press_9_bounce");
    cyc(3);
    pressed = 16'h0;
    cyc(20);

    // Short glitch produces nothing
    pc = pulse_cnt;
    pressed[10] = 1'b1;
    cyc(5);
    pressed[10] = 1'b0;
    cyc(40);
    chk("glitch_no_pulse", pulse_cnt, pc);

    // Hold '1', add '2' and '4', release with bounces
    pressed[0] = 1'b1;
    expect_key(4'h1);
    wait_sb("press_1");
    cyc(3);
    pc = pulse_cnt;
    pressed[1] = 1'b1;
    pressed[4] = 1'b1;
    cyc(20);
    chk("multi_col_frozen", {28'd0, col_n}, 32'hE);
    pressed = 16'h0;
    cyc(3);
    pressed = 16'h0013;
    cyc(3);
    pressed = 16'h0;
    cyc(3);
    pressed = 16'h0013;
    cyc(3);
    pressed = 16'h0;
    cyc(30);
    chk("multi_no_extra_pulse", pulse_cnt, pc);
    chk("multi_code_kept", {28'd0, key_code}, 32'h1);
    c0 = col_n;
    cyc(4);
    chk("multi_scan_resumed", {28'd0, col_n}, {28'd0, c0[2:0], c0[3]});

    // Reset during debounce of 'F'
    pc = pulse_cnt;
    pressed[14] = 1'b1;
    t = 0;
    while (col_n != 4'hB && t < 40) begin
      cyc(1);
      t++;
    end
    chk("f_col_reached", {28'd0, col_n}, 32'hB);
    cyc(4);
    cyc(4);
    reset   = 1'b1;
    pressed = 16'h0;
    cyc(1);
    chk("rstdb_col_n",     {28'd0, col_n},    32'hE);
    chk("rstdb_key_valid", {31'd0, key_valid}, 32'd0);
    chk("rstdb_dig_new",   {28'd0, dig_new},  32'h0);
    chk("rstdb_dig_old",   {28'd0, dig_old},  32'h0);
    chk("rstdb_key_code",  {28'd0, key_code}, 32'h0);
    cyc(1);
    chk("rstdb_key_valid_next", {31'd0, key_valid}, 32'd0);
    cyc(2);
    reset = 1'b0;
    m_new = 4'h0;
    m_old = 4'h0;
    cyc(20);
    chk("rstdb_no_pulse", pulse_cnt, pc);
    chk("rstdb_digits_zero", {24'd0, dig_new, dig_old}, 32'h0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
